// File: rtl/arm_register_bank.sv
// arm_register_bank
//   ARM-style general-purpose register file. The top address (15 for the
//   default ADDR_W) holds no storage. Reads of that address return the
//   externally supplied R15 value (PC+8). Every other address is a
//   DATA_W-bit register.
//
// Ports
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active-high; clears R0-R14 and wins over WE3
//   A1   in   read port 1 address
//   A2   in   read port 2 address
//   A3   in   write address
//   WE3  in   write enable for port 3
//   WD3  in   write data
//   R15  in   value returned for reads of the top address
//   RD1  out  combinational read data for A1
//   RD2  out  combinational read data for A2
module arm_register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int                NREGS   = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] PC_ADDR = {ADDR_W{1'b1}};

  // Physical storage covers only the addresses below PC_ADDR.
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WE3 && (A3 != PC_ADDR)) begin
      regs[A3] <= WD3;
    end
  end

  // There is no write-through bypass. A write issued this cycle shows up
  // on the read ports only after the clock edge.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 == PC_ADDR) RD1 = R15;
    else               RD1 = regs[A1];
    if (A2 == PC_ADDR) RD2 = R15;
    else               RD2 = regs[A2];
  end

endmodule

// File: tb/tb_arm_register_bank.sv
module tb_arm_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3, R15;
  logic [31:0] RD1, RD2;

  int total = 0;
  int bad   = 0;

  // Reference contents of R0-R14. The model is valid once the first reset
  // has been seen.
  logic [31:0] model [15];
  bit          model_valid = 1'b0;

  arm_register_bank #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3),
    .WD3(WD3), .R15(R15), .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expect_read(input logic [3:0] a);
    if (a == 4'd15) return R15;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The model applies register-file semantics at each rising edge. Inputs
  // never change at the edge itself, so the pre-edge values are seen here.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) model[i] = 32'h0;
      model_valid = 1'b1;
    end else if (WE3 && A3 != 4'd15) begin
      model[A3] = WD3;
    end
  end

  // Continuous comparison in the middle of every cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      check("rd1_model", RD1, expect_read(A1));
      check("rd2_model", RD2, expect_read(A2));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; A1 = 4'd0; A2 = 4'd1; A3 = 4'd0; WE3 = 1'b0;
    WD3 = 32'h0; R15 = 32'h0;
    #1;

    // Reset
    rst = 1'b1; A1 = 4'd0; A2 = 4'd1;
    cycle();
    rst = 1'b0;
    #1;
    check("reset_rd1", RD1, 32'h0);
    check("reset_rd2", RD2, 32'h0);

    // Basic write, then hold for several cycles
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h3E;
    cycle();
    WE3 = 1'b0; A1 = 4'd2; WD3 = 32'hFFFF_FFFF;
    #1;
    check("write_r2", RD1, 32'h3E);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("hold_r2", RD1, 32'h3E);
    end

    // R15 pass-through, no clock edge needed
    A1 = 4'd15; R15 = 32'h0000_1008;
    #1;
    check("r15_pass", RD1, 32'h1008);
    R15 = 32'h2000;
    #1;
    check("r15_track", RD1, 32'h2000);

    // A write to address 15 is ignored
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'hDEAD;
    cycle();
    WE3 = 1'b0;
    #1;
    check("wr15_ignored", RD1, 32'h2000);

    // Reset has priority over a write in the same cycle
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h55;
    cycle();
    A1 = 4'd3;
    #1;
    check("r3_written", RD1, 32'h55);
    rst = 1'b1; WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hAA;
    cycle();
    rst = 1'b0; WE3 = 1'b0; A1 = 4'd3; A2 = 4'd2;
    #1;
    check("rst_prio_r3", RD1, 32'h0);
    check("rst_clear_r2", RD2, 32'h0);

    // No bypass, with both ports on the same address
    WE3 = 1'b1; A3 = 4'd4; WD3 = 32'h1;
    cycle();
    A1 = 4'd4; A2 = 4'd4; A3 = 4'd4; WD3 = 32'h7; WE3 = 1'b1;
    #1;
    check("nobypass_rd1", RD1, 32'h1);
    check("nobypass_rd2", RD2, 32'h1);
    cycle();
    WE3 = 1'b0;
    #1;
    check("after_edge_rd1", RD1, 32'h7);
    check("after_edge_rd2", RD2, 32'h7);

    // Randomized traffic, checked by the negedge compare process
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      WE3 = ($urandom_range(0, 99) < 60);
      A1  = 4'($urandom_range(0, 15));
      A2  = ($urandom_range(0, 3) == 0) ? A1 : 4'($urandom_range(0, 15));
      A3  = 4'($urandom_range(0, 15));
      WD3 = $urandom;
      if ($urandom_range(0, 3) == 0) R15 = $urandom;
      #2;
      if ($urandom_range(0, 7) == 0) R15 = $urandom;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
